// File: rtl/aes256_key_sched_seq.sv
// Iterative AES-256 key expansion: loads a 256-bit key, generates the 60-word
// schedule one word per clock using an external SubWord S-box, and serves round keys.
module aes256_key_sched_seq #(
    parameter int NK = 8,
    parameter int NR = 14,
    parameter int NW = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic [31:0]  sw_in,
    input  logic [31:0]  sw_out
);

    localparam logic [5:0] NK6   = 6'(NK);
    localparam logic [5:0] LAST6 = 6'(NW - 1);
    localparam logic [3:0] NR4   = 4'(NR);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

    state_t         state_reg;
    logic [255:0]   key_reg;
    logic [5:0]     i_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           rk_valid_reg;
    logic [127:0]   rk_out_reg;

    // Sized to the full 6-bit index space so i-1 / i-8 never address past the end.
    logic [31:0]    w_mem [0:63];
    logic [31:0]    key_words [0:NK-1];

    logic [31:0]    prev_word;
    logic [31:0]    back_word;
    logic [31:0]    temp_next;
    logic [31:0]    word_next;
    logic [7:0]     rcon;
    logic [5:0]     rk_base;

    genvar gi;
    generate
        for (gi = 0; gi < NK; gi++) begin : g_key_words
            assign key_words[gi] = key_reg[255 - 32*gi -: 32];
        end
    endgenerate

    assign prev_word = w_mem[i_reg - 6'd1];
    assign back_word = w_mem[i_reg - NK6];
    assign rcon      = 8'h01 << (i_reg[5:3] - 3'd1);

    always_comb begin
        sw_in     = prev_word;
        temp_next = prev_word;
        if (i_reg[2:0] == 3'd0) begin
            sw_in     = {prev_word[23:0], prev_word[31:24]};
            temp_next = sw_out ^ {rcon, 24'h000000};
        end else if (i_reg[2:0] == 3'd4) begin
            temp_next = sw_out;
        end
    end

    assign word_next = back_word ^ temp_next;

    // Schedule storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (state_reg == LOAD) begin
            for (int k = 0; k < NK; k++) begin
                w_mem[k] <= key_words[k];
            end
        end else if (state_reg == EXPAND) begin
            w_mem[i_reg] <= word_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            i_reg        <= 6'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rk_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        key_reg      <= key_in;
                        busy_reg     <= 1'b1;
                        rk_valid_reg <= 1'b0;
                        state_reg    <= LOAD;
                    end
                end
                LOAD: begin
                    i_reg     <= NK6;
                    state_reg <= EXPAND;
                end
                EXPAND: begin
                    i_reg <= i_reg + 6'd1;
                    if (i_reg == LAST6) begin
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        rk_valid_reg <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rk_base = {rk_idx, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            rk_out_reg <= '0;
        end else if (rk_idx <= NR4) begin
            rk_out_reg <= {w_mem[rk_base], w_mem[rk_base + 6'd1],
                           w_mem[rk_base + 6'd2], w_mem[rk_base + 6'd3]};
        end else begin
            rk_out_reg <= '0;
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign rk_valid = rk_valid_reg;
    assign rk_out   = rk_out_reg;

endmodule

// File: tb/tb_aes256_key_sched_seq.sv
// Self-checking bench for aes256_key_sched_seq: supplies the external S-box and
// compares round keys against a word-level FIPS-197 expansion model.
module tb_aes256_key_sched_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic [31:0]  sw_in;
    logic [31:0]  sw_out;

    logic [7:0]   sbox_tbl [0:255];
    logic [31:0]  ref_w [0:59];
    int           n_checks = 0;
    int           n_fail = 0;

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    aes256_key_sched_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .done     (done),
        .rk_valid (rk_valid),
        .rk_idx   (rk_idx),
        .rk_out   (rk_out),
        .sw_in    (sw_in),
        .sw_out   (sw_out)
    );

    always #5 clk = ~clk;

    assign sw_out = {sbox_tbl[sw_in[31:24]], sbox_tbl[sw_in[23:16]],
                     sbox_tbl[sw_in[15:8]],  sbox_tbl[sw_in[7:0]]};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotb(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) begin
                    inv = 8'(b);
                    break;
                end
            end
            sbox_tbl[a] = inv ^ rotb(inv, 1) ^ rotb(inv, 2) ^ rotb(inv, 3)
                          ^ rotb(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
    endfunction

    task automatic build_ref(input logic [255:0] key);
        logic [7:0] rc = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < 8) begin
                ref_w[i] = key[255 - 32*i -: 32];
            end else begin
                logic [31:0] t = ref_w[i-1];
                if (i % 8 == 0) begin
                    t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (i % 8 == 4) begin
                    t = subword(t);
                end
                ref_w[i] = ref_w[i-8] ^ t;
            end
        end
    endtask

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    task automatic start_expand(input logic [255:0] key);
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 1;
        while (!done && cycles < 200) begin
            tick();
            cycles++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic read_rk(input int r);
        rk_idx = 4'(r);
        tick();
    endtask

    task automatic verify_all(input string tag);
        check({tag, "_rk_valid"}, rk_valid, 1'b1);
        for (int r = 0; r < 15; r++) begin
            read_rk(r);
            check($sformatf("%s_rk%0d", tag, r), rk_out, ref_rk(r));
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int valid_bad;
        logic [255:0] rkey;

        build_sbox();
        reset  = 1'b1;
        start  = 1'b0;
        key_in = '0;
        rk_idx = 4'd0;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_rk_valid", rk_valid, 1'b0);
        check("reset_rk_out", rk_out, 128'h0);

        // FIPS A.3 key: latency, one-cycle done, known round keys
        build_ref(KEY_A3);
        start_expand(KEY_A3);
        check("a3_busy", busy, 1'b1);
        wait_done("a3", lat);
        check("a3_latency", 128'(lat), 128'd54);
        check("a3_busy_at_done", busy, 1'b0);
        tick();
        check("a3_done_pulse", done, 1'b0);
        read_rk(0);
        check("a3_kat_rk0", rk_out, 128'h603deb1015ca71be2b73aef0857d7781);
        read_rk(2);
        check("a3_kat_rk2", rk_out, 128'h9ba354118e6925afa51a8b5f2067fcde);
        read_rk(14);
        check("a3_kat_rk14", rk_out, 128'hfe4890d1e6188d0b046df344706c631e);
        verify_all("a3");

        // FIPS C.3 key and out-of-range index
        build_ref(KEY_C3);
        start_expand(KEY_C3);
        wait_done("c3", lat);
        read_rk(14);
        check("c3_kat_rk14", rk_out, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        read_rk(15);
        check("c3_rk15_zero", rk_out, 128'h0);
        verify_all("c3");

        // Random keys against the model
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 8; k++) rkey[32*k +: 32] = $urandom;
            build_ref(rkey);
            start_expand(rkey);
            wait_done($sformatf("rnd%0d", n), lat);
            check($sformatf("rnd%0d_latency", n), 128'(lat), 128'd54);
            verify_all($sformatf("rnd%0d", n));
        end

        // Second start while busy, with a different key, must be ignored
        build_ref(KEY_A3);
        start_expand(KEY_A3);
        pulses = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 20) begin
                key_in = KEY_C3;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) pulses++;
        end
        start = 1'b0;
        check("busy_start_done_pulses", 128'(pulses), 128'd1);
        verify_all("busy_start");

        // Reset mid-expansion, then a fresh A.3 expansion
        for (int k = 0; k < 8; k++) rkey[32*k +: 32] = $urandom;
        start_expand(rkey);
        for (int c = 0; c < 29; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_rk_valid", rk_valid, 1'b0);
        check("midrst_rk_out", rk_out, 128'h0);
        build_ref(KEY_A3);
        start_expand(KEY_A3);
        valid_bad = 0;
        lat = 1;
        while (!done && lat < 200) begin
            if (rk_valid) valid_bad++;
            tick();
            lat++;
        end
        check("midrst_done_seen", done, 1'b1);
        check("midrst_valid_early", 128'(valid_bad), 128'd0);
        check("midrst_latency", 128'(lat), 128'd54);
        verify_all("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes256_key_sched_seq.md
Name: aes256_key_sched_seq

Overview:
- Iterative AES-256 key-expansion stage that sits directly upstream of the AES-256 encrypt/decrypt datapath in wrapper_256.
- Accepts a 256-bit cipher key and generates the 60-word FIPS-197 key schedule at one word per clock.
- Stores the schedule internally and serves any of the 15 round keys through a registered read port, so the cipher and inverse cipher can index keys in either order.
- Uses one external, shared combinational 4-byte S-box (SubWord) through a lookup port pair; this block contains no S-box table.

Parameters:
- NK, 8, key length in 32-bit words; fixed at 8, other values unsupported.
- NR, 14, number of rounds; round-key indices run 0..NR.
- NW, 60, total schedule words = 4*(NR+1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request expansion of key_in; sampled only when not busy.
- key_in  input  256  cipher key; key_in[255:224] = w[0] ... key_in[31:0] = w[7].
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the schedule is complete.
- rk_valid  output  1  high while a complete schedule is held.
- rk_idx  input  4  round-key index 0..14.
- rk_out  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r = rk_idx, registered.
- sw_in  output  32  word presented to the external SubWord S-box.
- sw_out  input  32  SubWord(sw_in); combinational, same-cycle return.

Behaviour:
- Reset values: busy=0, done=0, rk_valid=0, rk_out=0, state=IDLE, word counter=0. Word storage is not cleared.
- Reset mid-expansion aborts to IDLE with rk_valid=0. A later start must produce a correct schedule.
- FSM states: IDLE, LOAD, EXPAND, DONE.
- IDLE, start=1: latch key_in, go to LOAD, busy=1. If rk_valid was set, it clears in that same edge.
- LOAD: one cycle; write w[0..7] from the latched key; set i=8; go to EXPAND.
- EXPAND: write exactly one word per cycle, w[i] = w[i-8] ^ temp, where:
  - i mod 8 = 0: temp = sw_out ^ {Rcon[i/8], 24'h0}, with sw_in = RotWord(w[i-1]) (left rotate by one byte).
  - i mod 8 = 4: temp = sw_out, with sw_in = w[i-1].
  - otherwise: temp = w[i-1]; sw_in is don't-care but must hold w[i-1].
- Rcon[1..7] = 01, 02, 04, 08, 10, 20, 40 (hex).
- After w[59] is written, go to DONE.
- DONE: one cycle; done=1, busy=0, rk_valid=1; go to IDLE.
- Latency: start accepted at edge E0; LOAD occupies E0..E1; w[8]..w[59] written at edges E2..E53; done is high in the cycle after E53. Start to done = 54 cycles.
- start while busy: ignored, no queueing. start held high through DONE: treated as a new request once back in IDLE.
- key_in is sampled only at acceptance; later changes have no effect on the schedule in progress.
- Read port: rk_out is updated every cycle from rk_idx, 1-cycle latency.
  - rk_idx > 14: rk_out = 0.
  - Reads while rk_valid=0 return undefined content; the consumer must gate on rk_valid.
- Simultaneous reset and start: reset wins.

Test Plan:
- Reset then idle 10 cycles -> busy=0, done=0, rk_valid=0, rk_out=0.
- key_in=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, start pulse -> done exactly 54 cycles after start accepted; rk_idx=0 gives 603deb1015ca71be2b73aef0857d7781; rk_idx=2 gives 9ba354118e6925afa51a8b5f2067fcde; rk_idx=14 gives fe4890d1e6188d0b046df344706c631e.
- key_in=000102...1e1f, start -> rk_idx=14 gives 24fc79ccbf0979e9371ac23c6d68de36; rk_idx=15 gives 0.
- Pulse start again at cycle 20 of an expansion, with a different key_in -> ignored; result matches the first key; only one done pulse.
- Assert reset at cycle 30 of an expansion, then start with the A.3 key -> rk_valid stays 0 until the new done; all 15 round keys then match reference values.
- Drive wrapper_256's key input from rk_out for rounds 0..14 -> the wrapper's checkOut=1.
